circle_control: RTL and testbench
=================================

CIRCLE_CONTROL -- requirements
Module: circle_control

Interface
REQ-001 The module SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high; returns the block to IDLE.
REQ-004 start  in  1  level request to clear the screen and draw one circle.
REQ-005 colour_in  in  3  circle colour, sampled when IDLE accepts start.
REQ-006 c_done, crit_pos, loop_done, x_done, y_done  in  1 each  status flags from the circle datapath.
REQ-007 x_start, y_start, x_enable, y_enable  out  1 each  pixel x/y register controls.
REQ-008 counter_start, counter_enable  out  1 each  octant counter clear and increment.
REQ-009 x_off_enable, y_off_enable, crit_enable, crit_sel  out  1 each  algorithm register controls.
REQ-010 blank  out  1  selects the clear/initialise paths in the datapath.
REQ-011 plot  out  1  one-cycle pixel write strobe to the VGA adapter.
REQ-012 colour  out  3  pixel colour accompanying plot.
REQ-013 dp_resetn  out  1  active-low datapath register clear.
REQ-014 done  out  1  high while a completed drawing is held.

Function
REQ-015 The FSM SHALL have exactly these states: IDLE, CLR_INIT, CLR_ROW, CIRC_INIT, OCT_LOAD, OCT_PLOT, STEP, CHECK, DONE.
REQ-016 Every output not listed for a state SHALL be 0 in that state, except dp_resetn, which SHALL be 1 unless stated otherwise.
REQ-017 IDLE: on start=1, latch colour_in into an internal register and go to CLR_INIT; otherwise stay in IDLE.
REQ-018 CLR_INIT: dp_resetn=0, blank=1, x_start=y_start=x_enable=y_enable=1; go to CLR_ROW.
REQ-019 CLR_ROW priority 1, y_done=1: plot=0; go to CIRC_INIT.
REQ-020 CLR_ROW priority 2, x_done=1: blank=1, x_start=1, x_enable=y_enable=1 (x wraps to 0, y increments), plot=0; stay in CLR_ROW.
REQ-021 CLR_ROW otherwise: blank=1, plot=1, colour=3'b000, x_enable=1 (x increments); stay in CLR_ROW.
REQ-022 A plot pulse in CLR_ROW SHALL never coincide with x=160 or y=120.
REQ-023 CIRC_INIT: blank=1, crit_enable=1, x_off_enable=1 (crit=-9, offsetx=10), counter_start=1; go to OCT_LOAD.
REQ-024 OCT_LOAD: blank=0, x_enable=y_enable=1 (load the octant point selected by counter); go to OCT_PLOT.
REQ-025 OCT_PLOT: plot=1, colour=latched colour, counter_enable=1.
REQ-026 OCT_PLOT exit: if c_done=1 go to STEP, else go to OCT_LOAD.
REQ-027 Each algorithm iteration SHALL therefore issue exactly 9 plot pulses (counter 0..8; count 8 repeats octant 7).
REQ-028 STEP: y_off_enable=1, crit_enable=1, crit_sel=crit_pos, x_off_enable=crit_pos, counter_start=1; go to CHECK.
REQ-029 The crit_pos value used in STEP SHALL be the one sampled before the update.
REQ-030 CHECK: if loop_done=1 go to DONE, else go to OCT_LOAD.
REQ-031 DONE: done=1; go to IDLE when start=0, otherwise hold DONE.
REQ-032 Holding start high SHALL NOT retrigger a drawing.
REQ-033 plot SHALL never be high for two consecutive cycles outside CLR_ROW.
REQ-034 start changes after IDLE has accepted it SHALL be ignored until DONE.
REQ-035 colour_in changes after IDLE has accepted start SHALL be ignored until DONE.

Reset
REQ-036 While reset=1 on a clock edge: state=IDLE, colour register=0, done=0, all strobes/enables=0, blank=0, dp_resetn=0.
REQ-037 Reset asserted in any state, including mid-clear or mid-octant, SHALL take effect on the next edge with no further plot pulses.
REQ-038 After reset deasserts, the block SHALL stay in IDLE until start=1 is sampled.

Verification
REQ-039 Reset pulse with start=0 -> IDLE, plot=0, done=0, dp_resetn=0 during reset then 1.
REQ-040 start=1, colour_in=3'b010 -> exactly 19200 plot pulses with colour=0 covering x 0..159, y 0..119 once each, then CIRC_INIT.
REQ-041 First circle plot -> (x,y)=(90,60), colour=3'b010; first 9 circle plots -> octant points 0..7 plus a repeat of octant 7.
REQ-042 Full run -> circle plot count is a multiple of 9; done=1 after loop_done; all circle points satisfy |dx|,|dy|<=10 about (80,60).
REQ-043 Reset asserted mid-CLR_ROW and mid-OCT_PLOT -> next cycle plot=0, state IDLE; a new start redraws correctly from CLR_INIT.
REQ-044 start held high through DONE -> done stays 1, no new plots; start low -> IDLE in one cycle.

Source files
------------

// File: rtl/circle_control.sv
// circle_control: sequencer that clears the 160x120 screen, then drives a midpoint-circle datapath.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module circle_control (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] colour_in,
  input  logic       c_done,
  input  logic       crit_pos,
  input  logic       loop_done,
  input  logic       x_done,
  input  logic       y_done,
  output logic       x_start,
  output logic       y_start,
  output logic       x_enable,
  output logic       y_enable,
  output logic       counter_start,
  output logic       counter_enable,
  output logic       x_off_enable,
  output logic       y_off_enable,
  output logic       crit_enable,
  output logic       crit_sel,
  output logic       blank,
  output logic       plot,
  output logic [2:0] colour,
  output logic       dp_resetn,
  output logic       done
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] CLR_INIT  = 4'd1;
  localparam logic [3:0] CLR_ROW   = 4'd2;
  localparam logic [3:0] CIRC_INIT = 4'd3;
  localparam logic [3:0] OCT_LOAD  = 4'd4;
  localparam logic [3:0] OCT_PLOT  = 4'd5;
  localparam logic [3:0] STEP      = 4'd6;
  localparam logic [3:0] CHECK     = 4'd7;
  localparam logic [3:0] DONE      = 4'd8;

  logic [3:0] state;
  logic [3:0] state_next;
  logic [2:0] colour_reg;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      colour_reg <= 3'b000;
    end else begin
      state <= state_next;
      if (state == IDLE && start)
        colour_reg <= colour_in;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = CLR_INIT;
      CLR_INIT:  state_next = CLR_ROW;
      CLR_ROW:   if (y_done) state_next = CIRC_INIT;
      CIRC_INIT: state_next = OCT_LOAD;
      OCT_LOAD:  state_next = OCT_PLOT;
      OCT_PLOT:  state_next = c_done ? STEP : OCT_LOAD;
      STEP:      state_next = CHECK;
      CHECK:     state_next = loop_done ? DONE : OCT_LOAD;
      DONE:      if (!start) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs are decoded from state; reset forces them quiet within the same cycle.
  always_comb begin
    x_start        = 1'b0;
    y_start        = 1'b0;
    x_enable       = 1'b0;
    y_enable       = 1'b0;
    counter_start  = 1'b0;
    counter_enable = 1'b0;
    x_off_enable   = 1'b0;
    y_off_enable   = 1'b0;
    crit_enable    = 1'b0;
    crit_sel       = 1'b0;
    blank          = 1'b0;
    plot           = 1'b0;
    colour         = 3'b000;
    dp_resetn      = 1'b1;
    done           = 1'b0;
    case (state)
      CLR_INIT: begin
        dp_resetn = 1'b0;
        blank     = 1'b1;
        x_start   = 1'b1;
        y_start   = 1'b1;
        x_enable  = 1'b1;
        y_enable  = 1'b1;
      end
      CLR_ROW: begin
        if (y_done) begin
          plot = 1'b0;
        end else if (x_done) begin
          blank    = 1'b1;
          x_start  = 1'b1;
          x_enable = 1'b1;
          y_enable = 1'b1;
        end else begin
          blank    = 1'b1;
          plot     = 1'b1;
          colour   = 3'b000;
          x_enable = 1'b1;
        end
      end
      CIRC_INIT: begin
        blank         = 1'b1;
        crit_enable   = 1'b1;
        x_off_enable  = 1'b1;
        counter_start = 1'b1;
      end
      OCT_LOAD: begin
        x_enable = 1'b1;
        y_enable = 1'b1;
      end
      OCT_PLOT: begin
        plot           = 1'b1;
        colour         = colour_reg;
        counter_enable = 1'b1;
      end
      STEP: begin
        y_off_enable  = 1'b1;
        crit_enable   = 1'b1;
        crit_sel      = crit_pos;
        x_off_enable  = crit_pos;
        counter_start = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
    if (reset) begin
      x_start        = 1'b0;
      y_start        = 1'b0;
      x_enable       = 1'b0;
      y_enable       = 1'b0;
      counter_start  = 1'b0;
      counter_enable = 1'b0;
      x_off_enable   = 1'b0;
      y_off_enable   = 1'b0;
      crit_enable    = 1'b0;
      crit_sel       = 1'b0;
      blank          = 1'b0;
      plot           = 1'b0;
      colour         = 3'b000;
      dp_resetn      = 1'b0;
      done           = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_circle_control.sv
// tb_circle_control: drives circle_control against a behavioural datapath and checks plotted pixels.
// Revision 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_circle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] colour_in = 3'b000;
  logic       c_done, crit_pos, loop_done, x_done, y_done;
  logic       x_start, y_start, x_enable, y_enable;
  logic       counter_start, counter_enable;
  logic       x_off_enable, y_off_enable, crit_enable, crit_sel;
  logic       blank, plot, dp_resetn, done;
  logic [2:0] colour;

  always #5 clk = ~clk;

  circle_control dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .colour_in(colour_in),
    .c_done(c_done), .crit_pos(crit_pos), .loop_done(loop_done),
    .x_done(x_done), .y_done(y_done),
    .x_start(x_start), .y_start(y_start), .x_enable(x_enable), .y_enable(y_enable),
    .counter_start(counter_start), .counter_enable(counter_enable),
    .x_off_enable(x_off_enable), .y_off_enable(y_off_enable),
    .crit_enable(crit_enable), .crit_sel(crit_sel),
    .blank(blank), .plot(plot), .colour(colour),
    .dp_resetn(dp_resetn), .done(done)
  );

  // Behavioural circle datapath centred on (80,60), radius 10.
  int x = 0, y = 0, cnt = 0, offx = 0, offy = 0, crit = 0;
  int oct_x, oct_y;

  function automatic int oct_dx(input int k, input int ox, input int oy);
    case (k)
      0: return ox;   1: return oy;   2: return -oy;  3: return -ox;
      4: return -ox;  5: return -oy;  6: return oy;   default: return ox;
    endcase
  endfunction

  function automatic int oct_dy(input int k, input int ox, input int oy);
    case (k)
      0: return oy;   1: return ox;   2: return ox;   3: return oy;
      4: return -oy;  5: return -ox;  6: return -ox;  default: return -oy;
    endcase
  endfunction

  always_comb begin
    oct_x     = oct_dx(cnt, offx, offy);
    oct_y     = oct_dy(cnt, offx, offy);
    x_done    = (x == 160);
    y_done    = (y == 120);
    c_done    = (cnt == 8);
    crit_pos  = (crit > 0);
    loop_done = (offy > offx);
  end

  always @(posedge clk) begin
    if (x_enable) x <= blank ? (x_start ? 0 : x + 1) : 80 + oct_x;
    if (y_enable) y <= blank ? (y_start ? 0 : y + 1) : 60 + oct_y;
    if (!dp_resetn) begin
      cnt <= 0; offx <= 0; offy <= 0; crit <= 0;
    end else begin
      if (counter_start) cnt <= 0;
      else if (counter_enable) cnt <= cnt + 1;
      if (x_off_enable) offx <= blank ? 10 : offx - 1;
      if (y_off_enable) offy <= blank ? 0 : offy + 1;
      if (crit_enable)
        crit <= blank ? -9 : (crit_sel ? crit + 2 * (offy - offx + 2) + 1
                                       : crit + 2 * (offy + 1) + 1);
    end
  end

  // Plot monitor, restarted whenever run_id changes.
  typedef struct { int px; int py; int pc; } pt_t;
  pt_t circ_q[$];
  pt_t ref_q[$];
  int  cov [0:19199];
  int  run_id = 0, seen_run = 0;
  int  clr_cnt = 0, clr_badcol = 0, clr_oob = 0, consec = 0, plot_total = 0;
  bit  in_circle = 0, prev_cp = 0;

  always @(negedge clk) begin
    if (run_id != seen_run) begin
      seen_run   <= run_id;
      clr_cnt    <= 0; clr_badcol <= 0; clr_oob <= 0;
      consec     <= 0; plot_total <= 0;
      in_circle  <= 0; prev_cp    <= 0;
      foreach (cov[i]) cov[i] <= 0;
      circ_q.delete();
    end else begin
      if (blank && crit_enable && counter_start) in_circle <= 1'b1;
      if (plot) begin
        plot_total <= plot_total + 1;
        if (!in_circle) begin
          clr_cnt <= clr_cnt + 1;
          if (colour != 3'b000) clr_badcol <= clr_badcol + 1;
          if (x >= 0 && x < 160 && y >= 0 && y < 120) cov[y * 160 + x] <= cov[y * 160 + x] + 1;
          else clr_oob <= clr_oob + 1;
        end else begin
          circ_q.push_back('{x, y, int'(colour)});
          if (prev_cp) consec <= consec + 1;
        end
      end
      prev_cp <= plot && in_circle;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  function automatic int activity();
    return int'(x_start | y_start | x_enable | y_enable | counter_start | counter_enable |
                x_off_enable | y_off_enable | crit_enable | crit_sel | blank | plot | done);
  endfunction

  // Expected circle: midpoint algorithm, 8-way symmetric via a sign/swap table.
  task automatic build_ref(input int col);
    int sx [8] = '{1, 1, -1, -1, -1, -1, 1, 1};
    int sy [8] = '{1, 1, 1, 1, -1, -1, -1, -1};
    bit sw [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    int ox = 10, oy = 0, d = 1 - 10;
    ref_q.delete();
    while (1) begin
      for (int k = 0; k < 9; k++) begin
        int o = (k > 7) ? 7 : k;
        ref_q.push_back('{80 + sx[o] * (sw[o] ? oy : ox), 60 + sy[o] * (sw[o] ? ox : oy), col});
      end
      oy++;
      if (d <= 0) d += 2 * oy + 1;
      else begin ox--; d += 2 * (oy - ox) + 1; end
      if (oy > ox) break;
    end
  endtask

  task automatic new_run();
    run_id++;
    tick();
  endtask

  task automatic quiet_check(input string tag, input int cycles);
    int act = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      act += activity();
    end
    check_eq(tag, act, 0);
  endtask

  task automatic run_full(input logic [2:0] col);
    bit got_done = 0;
    int uncov = 0, mis = 0, far = 0, n, snap, held = 0;
    new_run();
    build_ref(int'(col));
    start = 1'b1; colour_in = col;
    tick();
    check_eq("clr_init_dp_resetn", int'(dp_resetn), 0);
    check_eq("clr_init_blank", int'(blank), 1);
    for (int i = 0; i < 30000 && !got_done; i++) begin
      if (done) got_done = 1;
      else begin
        colour_in = 3'($urandom);
        start = (i < 1000) ? 1'($urandom) : 1'b1;
        tick();
      end
    end
    check_eq("done_reached", int'(got_done), 1);
    check_eq("clr_plot_count", clr_cnt, 19200);
    check_eq("clr_colour_bad", clr_badcol, 0);
    check_eq("clr_out_of_range", clr_oob, 0);
    foreach (cov[i]) if (cov[i] != 1) uncov++;
    check_eq("clr_pixels_not_once", uncov, 0);
    n = circ_q.size();
    check_eq("circ_count", n, ref_q.size());
    check_eq("circ_mult9", n % 9, 0);
    if (n > 0) begin
      check_eq("circ_first_x", circ_q[0].px, 90);
      check_eq("circ_first_y", circ_q[0].py, 60);
      check_eq("circ_first_colour", circ_q[0].pc, int'(col));
    end
    for (int i = 0; i < n; i++) begin
      if (i >= ref_q.size() || circ_q[i] != ref_q[i]) mis++;
      if (circ_q[i].px < 70 || circ_q[i].px > 90 || circ_q[i].py < 50 || circ_q[i].py > 70) far++;
    end
    check_eq("circ_point_mismatch", mis, 0);
    check_eq("circ_out_of_radius", far, 0);
    check_eq("circ_consecutive_plots", consec, 0);
    snap = plot_total;
    for (int i = 0; i < 20; i++) begin
      tick();
      held += int'(done);
    end
    check_eq("done_held", held, 20);
    check_eq("no_plot_while_held", plot_total - snap, 0);
    start = 1'b0;
    tick();
    check_eq("done_release", int'(done), 0);
    quiet_check("idle_after_done", 3);
  endtask

  initial begin
    bit seen = 0;
    // Power-on reset.
    tick();
    check_eq("rst_dp_resetn", int'(dp_resetn), 0);
    check_eq("rst_plot", int'(plot), 0);
    check_eq("rst_done", int'(done), 0);
    tick();
    reset = 1'b0;
    tick();
    check_eq("post_rst_dp_resetn", int'(dp_resetn), 1);
    quiet_check("idle_no_start", 5);

    run_full(3'b010);

    // Reset in the middle of the screen clear.
    new_run();
    start = 1'b1; colour_in = 3'($urandom);
    for (int i = 0; i < int'($urandom_range(50, 3000)); i++) begin
      tick();
      start = 1'($urandom);
    end
    reset = 1'b1;
    tick();
    check_eq("mid_clr_rst_plot", int'(plot), 0);
    check_eq("mid_clr_rst_dp_resetn", int'(dp_resetn), 0);
    reset = 1'b0; start = 1'b0;
    quiet_check("mid_clr_rst_idle", 4);

    // Reset while a circle point is being plotted.
    new_run();
    start = 1'b1; colour_in = 3'($urandom);
    for (int i = 0; i < 25000 && !seen; i++) begin
      tick();
      if (in_circle && plot) seen = 1;
    end
    check_eq("mid_oct_reached", int'(seen), 1);
    reset = 1'b1;
    tick();
    check_eq("mid_oct_rst_plot", int'(plot), 0);
    reset = 1'b0; start = 1'b0;
    quiet_check("mid_oct_rst_idle", 4);

    run_full(3'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
